// File: rtl/fle_cfg_param.sv
// Fracturable logic element with a serial configuration chain.
// A K-input LUT (splittable into two (K-1)-input LUTs) feeds two optional
// output flip-flops. Configuration is shifted in through ccff_head and
// passes on to the next tile through ccff_tail, tracked by a bit counter
// and a small load state machine that flags short loads.
module fle_cfg_param #(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [K-1:0] fle_in,
  input  logic         ff_ce,
  input  logic         ff_set,
  input  logic         ccff_en,
  input  logic         ccff_head,
  output logic [1:0]   fle_out,
  output logic         ccff_tail,
  output logic         cfg_done,
  output logic         cfg_err
);

  localparam int LUT_BITS = 2 ** K;
  localparam int CFG_BITS = LUT_BITS + 3;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  cfg_done_q;
  logic                  cfg_err_q;
  logic [CFG_BITS-1:0]   cfg_q;
  logic [CFG_BITS-1:0]   cfg_d;
  logic [LUT_BITS-1:0]   lut;
  logic                  frac;
  logic                  ready;

  // Next value of the configuration shift register.
  always_comb begin
    cfg_d = cfg_q;
    if (ccff_en) begin
      cfg_d = {cfg_q[CFG_BITS-2:0], ccff_head};
    end
  end

  // Configuration shift register; keeps shifting past a full load so extra
  // bits flow through to downstream tiles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= '0;
    end else begin
      cfg_q <= cfg_d;
    end
  end

  // Load state machine with saturating bit counter and registered status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_UNCFG;
      cnt_q      <= '0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_UNCFG, ST_READY: begin
          // The edge that enters LOAD is itself a shift, so it counts.
          if (ccff_en) begin
            state_q    <= ST_LOAD;
            cnt_q      <= CNT_W'(1);
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (ccff_en) begin
            if (cnt_q != CNT_FULL) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (cnt_q == CNT_FULL) begin
            state_q    <= ST_READY;
            cfg_done_q <= 1'b1;
          end else begin
            state_q   <= ST_UNCFG;
            cfg_err_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_UNCFG;
          cfg_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = (state_q == ST_READY);
  assign lut       = cfg_q[LUT_BITS-1:0];
  assign frac      = cfg_q[LUT_BITS];
  assign ccff_tail = cfg_q[CFG_BITS-1];
  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;

  // One slice per output: LUT half select, output flip-flop and output mux.
  for (genvar gi = 0; gi < 2; gi++) begin : g_out
    logic [K-1:0] idx;
    logic         comb;
    logic         out_reg;
    logic         ff_d;
    logic         ff_q;

    // In fractured mode the top address bit is replaced by the output number.
    assign idx     = frac ? {1'(gi), fle_in[K-2:0]} : fle_in;
    assign comb    = lut[idx];
    assign out_reg = cfg_q[LUT_BITS+1+gi];

    // Flip-flop next state: cleared while unconfigured, set beats enable.
    always_comb begin
      ff_d = ff_q;
      if (!ready) begin
        ff_d = 1'b0;
      end else if (ff_set) begin
        ff_d = 1'b1;
      end else if (ff_ce) begin
        ff_d = comb;
      end
    end

    // Output flip-flop storage.
    always_ff @(posedge clk) begin
      if (reset) begin
        ff_q <= 1'b0;
      end else begin
        ff_q <= ff_d;
      end
    end

    assign fle_out[gi] = ready & (out_reg ? ff_q : comb);
  end

endmodule

// File: tb/tb_fle_cfg_param.sv
// Self-checking bench for fle_cfg_param (K=4): directed steps followed by
// randomized configuration episodes, checked against a behavioural model
// that keeps the history of shifted bits and derives the fields from it.
module tb_fle_cfg_param;

  localparam int K        = 4;
  localparam int LUT_BITS = 2 ** K;
  localparam int CFG_BITS = LUT_BITS + 3;
  localparam int HALF     = LUT_BITS / 2;

  localparam int M_UNCFG = 0;
  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [K-1:0] fle_in;
  logic         ff_ce;
  logic         ff_set;
  logic         ccff_en;
  logic         ccff_head;
  logic [1:0]   fle_out;
  logic         ccff_tail;
  logic         cfg_done;
  logic         cfg_err;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model state.
  bit       hist[$];
  int       mst  = M_UNCFG;
  int       mlen = 0;
  bit       merr = 1'b0;
  bit [1:0] mff  = 2'b00;

  fle_cfg_param #(.K(K)) dut (
    .clk       (clk),
    .reset     (reset),
    .fle_in    (fle_in),
    .ff_ce     (ff_ce),
    .ff_set    (ff_set),
    .ccff_en   (ccff_en),
    .ccff_head (ccff_head),
    .fle_out   (fle_out),
    .ccff_tail (ccff_tail),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // Configuration = the last CFG_BITS bits shifted in, newest at bit 0.
  function automatic logic [CFG_BITS-1:0] m_cfg();
    logic [CFG_BITS-1:0] c;
    int sz;
    c  = '0;
    sz = hist.size();
    for (int i = 0; i < CFG_BITS; i++) begin
      if (i < sz) c[i] = hist[sz-1-i];
    end
    return c;
  endfunction

  function automatic logic m_comb(int n);
    logic [CFG_BITS-1:0] c;
    int idx;
    c = m_cfg();
    if (c[LUT_BITS]) idx = n * HALF + (int'(fle_in) % HALF);
    else             idx = int'(fle_in);
    return c[idx];
  endfunction

  function automatic logic [1:0] m_out();
    logic [CFG_BITS-1:0] c;
    logic [1:0] o;
    c = m_cfg();
    o = 2'b00;
    if (mst == M_READY) begin
      for (int n = 0; n < 2; n++) o[n] = c[LUT_BITS+1+n] ? mff[n] : m_comb(n);
    end
    return o;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    bit [1:0] nf;
    if (reset) begin
      hist.delete();
      mst  = M_UNCFG;
      mlen = 0;
      merr = 1'b0;
      mff  = 2'b00;
      return;
    end
    for (int n = 0; n < 2; n++) begin
      if (mst != M_READY) nf[n] = 1'b0;
      else if (ff_set)    nf[n] = 1'b1;
      else if (ff_ce)     nf[n] = m_comb(n);
      else                nf[n] = mff[n];
    end
    mff = nf;
    if (ccff_en) begin
      if (mst != M_LOAD) begin
        mlen = 0;
        merr = 1'b0;
      end
      mst = M_LOAD;
      mlen++;
      hist.push_back(ccff_head);
      if (hist.size() > CFG_BITS) void'(hist.pop_front());
    end else if (mst == M_LOAD) begin
      if (mlen >= CFG_BITS) begin
        mst = M_READY;
      end else begin
        mst  = M_UNCFG;
        merr = 1'b1;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [CFG_BITS-1:0] c;
    c = m_cfg();
    check({tag, "_out"},  32'(fle_out),   32'(m_out()));
    check({tag, "_tail"}, 32'(ccff_tail), 32'(c[CFG_BITS-1]));
    check({tag, "_done"}, 32'(cfg_done),  32'(mst == M_READY));
    check({tag, "_err"},  32'(cfg_err),   32'(merr));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Shift a full word MSB first (out1, out0, frac, lut[15..0]) then stop.
  task automatic load_word(input logic [CFG_BITS-1:0] w);
    for (int i = CFG_BITS - 1; i >= 0; i--) begin
      ccff_en   = 1'b1;
      ccff_head = w[i];
      tick();
    end
    ccff_en = 1'b0;
    tick();
    $display("load word=%05h done=%0b err=%0b", w, cfg_done, cfg_err);
  endtask

  initial begin
    logic [23:0] bits;

    // Step 1: reset with random inputs.
    reset     = 1'b1;
    fle_in    = K'($urandom);
    ff_ce     = 1'($urandom);
    ff_set    = 1'($urandom);
    ccff_en   = 1'($urandom);
    ccff_head = 1'($urandom);
    tick();
    fle_in    = K'($urandom);
    ff_set    = 1'b1;
    ccff_en   = 1'b1;
    tick();
    check_all("reset");
    check("reset_out_const", 32'(fle_out), 32'd0);
    check("reset_done_const", 32'(cfg_done), 32'd0);
    reset  = 1'b0;
    ff_ce  = 1'b0;
    ff_set = 1'b0;

    // Step 2: AND4, combinational outputs.
    load_word({3'b000, 16'h8000});
    check_all("and4_ready");
    check("and4_done_const", 32'(cfg_done), 32'd1);
    fle_in = 4'b1111; #1;
    check_all("and4_f");
    check("and4_f_const", 32'(fle_out), 32'd3);
    fle_in = 4'b1110; #1;
    check_all("and4_e");
    check("and4_e_const", 32'(fle_out), 32'd0);

    // Step 3: fractured mode, sweep every input (covers fle_in[3] toggling).
    load_word({3'b001, 16'hFE80});
    for (int v = 0; v < LUT_BITS; v++) begin
      fle_in = K'(v); #1;
      check_all($sformatf("frac_%0d", v));
    end
    fle_in = 4'b0111; #1;
    check("frac_7_const", 32'(fle_out), 32'd3);
    fle_in = 4'b1001; #1;
    check("frac_9_out0", 32'(fle_out[0]), 32'd0);
    check("frac_9_out1", 32'(fle_out[1]), 32'd1);
    fle_in = 4'b0000; #1;
    check("frac_0_const", 32'(fle_out), 32'd0);

    // Step 4: out0 registered.
    load_word({3'b010, 16'h8000});
    fle_in = 4'b1111; ff_ce = 1'b1; #1;
    check_all("reg_pre");
    tick();
    check_all("reg_cap");
    check("reg_cap_const", 32'(fle_out), 32'd3);
    fle_in = 4'b0000; ff_ce = 1'b0;
    tick();
    check_all("reg_hold");
    check("reg_hold_const", 32'(fle_out[0]), 32'd1);
    ff_ce = 1'b1;
    tick();
    check_all("reg_clr");
    ff_set = 1'b1;
    tick();
    check_all("reg_set");
    check("reg_set_const", 32'(fle_out[0]), 32'd1);
    reset = 1'b1;
    tick();
    check_all("reg_rst");
    check("reg_rst_const", 32'(fle_out), 32'd0);
    reset = 1'b0; ff_set = 1'b0; ff_ce = 1'b0;

    // Step 5: short load then full load.
    for (int i = 0; i < 10; i++) begin
      ccff_en = 1'b1; ccff_head = 1'($urandom);
      tick();
    end
    ccff_en = 1'b0;
    tick();
    check_all("short");
    check("short_err_const", 32'(cfg_err), 32'd1);
    load_word(CFG_BITS'($urandom));
    check_all("after_short");
    check("after_short_err_const", 32'(cfg_err), 32'd0);

    // Step 6: over-long load with pass-through.
    bits = 24'($urandom);
    for (int i = 0; i < 24; i++) begin
      ccff_en = 1'b1; ccff_head = bits[i];
      fle_in = K'($urandom);
      tick();
      check_all($sformatf("long_%0d", i + 1));
      if (i + 1 == 19) check("long_tail_b0", 32'(ccff_tail), 32'(bits[0]));
      if (i + 1 == 23) check("long_tail_b4", 32'(ccff_tail), 32'(bits[4]));
    end
    ccff_en = 1'b0;
    tick();
    check_all("long_ready");
    check("long_tail_b5", 32'(ccff_tail), 32'(bits[5]));
    for (int v = 0; v < LUT_BITS; v += 5) begin
      fle_in = K'(v); #1;
      check_all($sformatf("long_eval_%0d", v));
    end
    ccff_en = 1'b1; ccff_head = 1'b0; fle_in = K'($urandom);
    tick();
    check_all("reconf");
    check("reconf_out_const", 32'(fle_out), 32'd0);
    ccff_en = 1'b0;
    tick();
    check_all("reconf_short");

    // Randomized episodes: mostly full loads, some short or long, rare resets.
    for (int ep = 0; ep < 25; ep++) begin
      int len;
      len = ($urandom_range(0, 2) != 0) ? CFG_BITS : int'($urandom_range(1, 30));
      for (int i = 0; i < len; i++) begin
        ccff_en = 1'b1; ccff_head = 1'($urandom);
        fle_in = K'($urandom); ff_ce = 1'($urandom); ff_set = ($urandom_range(0, 3) == 0);
        reset = ($urandom_range(0, 99) == 0);
        tick();
        check_all($sformatf("ep%0d_sh%0d", ep, i));
      end
      ccff_en = 1'b0; reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
        fle_in = K'($urandom); ff_ce = 1'($urandom); ff_set = ($urandom_range(0, 3) == 0);
        reset = ($urandom_range(0, 59) == 0);
        tick();
        check_all($sformatf("ep%0d_run%0d", ep, i));
      end
      reset = 1'b0;
      $display("episode %0d len=%0d done=%0b err=%0b", ep, len, cfg_done, cfg_err);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
